// File: rtl/expr_recognizer.sv
// Streaming recognizer for ASCII arithmetic expressions: multi-digit operands,
// maskable operator set and bounded parenthesis nesting, one char per valid cycle.
module expr_recognizer #(
  parameter int         MAX_DIGITS = 4,
  parameter int         MAX_DEPTH  = 3,
  parameter logic [3:0] OP_MASK    = 4'b1111,
  parameter int         CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           clr_n,
  input  logic                           in_valid,
  input  logic [7:0]                     in,
  output logic                           out,
  output logic                           err,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
  output logic [CNT_W-1:0]               term_cnt
);

  localparam int DW  = $clog2(MAX_DEPTH+1);
  localparam int DCW = $clog2(MAX_DIGITS+1);

  typedef enum logic [1:0] {EXPECT_TERM, IN_NUM, AFTER_TERM, FAIL} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  logic             out_q, out_d;
  logic             err_q, err_d;

  logic is_digit, is_op, is_lp, is_rp;

  // Operators whose mask bit is clear fall through to OTHER.
  always_comb begin
    is_digit = (in >= "0") && (in <= "9");
    is_op    = ((in == "+") && OP_MASK[0]) || ((in == "-") && OP_MASK[1]) ||
               ((in == "*") && OP_MASK[2]) || ((in == "/") && OP_MASK[3]);
    is_lp    = (in == "(");
    is_rp    = (in == ")");
  end

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    dcnt_d     = dcnt_q;
    term_cnt_d = term_cnt_q;
    out_d      = out_q;
    err_d      = err_q;
    if (in_valid) begin
      state_d = FAIL;
      case (state_q)
        EXPECT_TERM: begin
          if (is_digit) begin
            state_d = IN_NUM;
            dcnt_d  = DCW'(1);
          end else if (is_lp && (depth_q < DW'(MAX_DEPTH))) begin
            state_d = EXPECT_TERM;
            depth_d = depth_q + 1'b1;
          end
        end
        IN_NUM: begin
          if (is_digit && (dcnt_q < DCW'(MAX_DIGITS))) begin
            state_d = IN_NUM;
            dcnt_d  = dcnt_q + 1'b1;
          end else if (is_op) begin
            state_d = EXPECT_TERM;
            dcnt_d  = '0;
            if (term_cnt_q != '1) term_cnt_d = term_cnt_q + 1'b1;
          end else if (is_rp && (depth_q != '0)) begin
            state_d = AFTER_TERM;
            dcnt_d  = '0;
            depth_d = depth_q - 1'b1;
            if (term_cnt_q != '1) term_cnt_d = term_cnt_q + 1'b1;
          end
        end
        AFTER_TERM: begin
          if (is_op) begin
            state_d = EXPECT_TERM;
          end else if (is_rp && (depth_q != '0)) begin
            state_d = AFTER_TERM;
            depth_d = depth_q - 1'b1;
          end
        end
        default: state_d = FAIL;
      endcase
      // Entering FAIL freezes the counters at their pre-error values.
      if (state_d == FAIL) begin
        depth_d    = depth_q;
        term_cnt_d = term_cnt_q;
        dcnt_d     = '0;
      end
      out_d = ((state_d == IN_NUM) || (state_d == AFTER_TERM)) && (depth_d == '0);
      err_d = (state_d == FAIL);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= EXPECT_TERM;
      depth_q    <= '0;
      dcnt_q     <= '0;
      term_cnt_q <= '0;
      out_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      dcnt_q     <= dcnt_d;
      term_cnt_q <= term_cnt_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  assign out      = out_q;
  assign err      = err_q;
  assign depth    = depth_q;
  assign term_cnt = term_cnt_q;

endmodule

// File: tb/tb_expr_recognizer.sv
// Directed bench: expected outputs queued per driven char, popped after the edge.
module tb_expr_recognizer;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;

  logic       out_a, err_a, out_m, err_m;
  logic [1:0] depth_a, depth_m;
  logic [7:0] tc_a, tc_m;

  int  tests = 0;
  int  fails = 0;
  bit  sel_m = 1'b0;

  typedef struct packed {
    logic       o;
    logic       e;
    logic [1:0] d;
    logic [7:0] tc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  expr_recognizer dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(in),
    .out(out_a), .err(err_a), .depth(depth_a), .term_cnt(tc_a)
  );

  expr_recognizer #(.OP_MASK(4'b0101)) dut_m (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(in),
    .out(out_m), .err(err_m), .depth(depth_m), .term_cnt(tc_m)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      x = sb.pop_front();
      chk({tag, ".out"},      sel_m ? int'(out_m)   : int'(out_a),   int'(x.o));
      chk({tag, ".err"},      sel_m ? int'(err_m)   : int'(err_a),   int'(x.e));
      chk({tag, ".depth"},    sel_m ? int'(depth_m) : int'(depth_a), int'(x.d));
      chk({tag, ".term_cnt"}, sel_m ? int'(tc_m)    : int'(tc_a),    int'(x.tc));
    end
  endtask

  // Called at posedge+1; drives one cycle, checks at the following posedge+1.
  task automatic step(input string tag, input byte ch, input bit v,
                      input bit o, input bit e, input int d, input int tc);
    in       = ch;
    in_valid = v;
    sb.push_back({o, e, 2'(d), 8'(tc)});
    @(posedge clk);
    #1;
    compare(tag);
    in_valid = 1'b0;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear with no clock.
  task automatic do_reset(input string tag);
    clr_n = 1'b0;
    #2;
    sb.push_back('0);
    compare(tag);
    clr_n = 1'b1;
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset("reset");

    // "1+2*3"
    step("e1_1", "1", 1, 1, 0, 0, 0);
    step("e1_+", "+", 1, 0, 0, 0, 1);
    step("e1_2", "2", 1, 1, 0, 0, 1);
    step("e1_*", "*", 1, 0, 0, 0, 2);
    step("e1_3", "3", 1, 1, 0, 0, 2);

    // Digit-run limit, then error is sticky
    @(posedge clk); #1; do_reset("rst2");
    step("dg_1", "1", 1, 1, 0, 0, 0);
    step("dg_2", "2", 1, 1, 0, 0, 0);
    step("dg_3", "3", 1, 1, 0, 0, 0);
    step("dg_4", "4", 1, 1, 0, 0, 0);
    step("dg_5", "5", 1, 0, 1, 0, 0);
    step("dg_+", "+", 1, 0, 1, 0, 0);
    step("dg_7", "7", 1, 0, 1, 0, 0);

    // "((7))-8" then '(' right after a number is illegal
    @(posedge clk); #1; do_reset("rst3");
    step("pn_(1", "(", 1, 0, 0, 1, 0);
    step("pn_(2", "(", 1, 0, 0, 2, 0);
    step("pn_7",  "7", 1, 0, 0, 2, 0);
    step("pn_)1", ")", 1, 0, 0, 1, 1);
    step("pn_)2", ")", 1, 1, 0, 0, 1);
    step("pn_-",  "-", 1, 0, 0, 0, 1);
    step("pn_8",  "8", 1, 1, 0, 0, 1);
    step("pn_(x", "(", 1, 0, 1, 0, 1);

    // Nesting limit: 4th '(' fails, depth frozen at 3
    @(posedge clk); #1; do_reset("rst4");
    step("nd_1", "(", 1, 0, 0, 1, 0);
    step("nd_2", "(", 1, 0, 0, 2, 0);
    step("nd_3", "(", 1, 0, 0, 3, 0);
    step("nd_4", "(", 1, 0, 1, 3, 0);

    // Empty parentheses and unmatched ')'
    @(posedge clk); #1; do_reset("rst5");
    step("em_(", "(", 1, 0, 0, 1, 0);
    step("em_)", ")", 1, 0, 1, 1, 0);
    @(posedge clk); #1; do_reset("rst6");
    step("um_5", "5", 1, 1, 0, 0, 0);
    step("um_)", ")", 1, 0, 1, 0, 0);
    @(posedge clk); #1; do_reset("rst7");
    step("sp",   " ", 1, 0, 1, 0, 0);

    // Masked operator set on the second instance
    sel_m = 1'b1;
    @(posedge clk); #1; do_reset("rst8");
    step("mk_9",  "9", 1, 1, 0, 0, 0);
    step("mk_-",  "-", 1, 0, 1, 0, 0);
    step("mk_1",  "1", 1, 0, 1, 0, 0);
    @(posedge clk); #1; do_reset("rst9");
    step("mk2_9", "9", 1, 1, 0, 0, 0);
    step("mk2_*", "*", 1, 0, 0, 0, 1);
    step("mk2_1", "1", 1, 1, 0, 0, 1);
    sel_m = 1'b0;

    // Idle cycles hold state; junk on the bus is ignored
    @(posedge clk); #1; do_reset("rst10");
    step("iv_4",  "4", 1, 1, 0, 0, 0);
    step("iv_i1", "(", 0, 1, 0, 0, 0);
    step("iv_i2", "x", 0, 1, 0, 0, 0);
    step("iv_+",  "+", 1, 0, 0, 0, 1);
    step("iv_5",  "5", 1, 1, 0, 0, 1);

    // Mid-stream asynchronous reset
    @(posedge clk); #1; do_reset("rst11");
    step("mr_3", "3", 1, 1, 0, 0, 0);
    step("mr_+", "+", 1, 0, 0, 0, 1);
    step("mr_(", "(", 1, 0, 0, 1, 1);
    do_reset("mr_clr");
    @(posedge clk); #1;
    step("mr_6", "6", 1, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
